// File: rtl/spi_target_regs_pkg.sv
// Shared types and constants for the SPI target register block.
package cvw;

    // Frame progress: waiting for chip select, receiving command byte, moving data bytes.
    typedef enum logic [1:0] {
        SPIT_IDLE,
        SPIT_CMD,
        SPIT_DATA
    } spit_state_t;

    // Position of the read/not-write flag inside the command byte.
    localparam int SPIT_RNW_BIT = 7;

endpackage

// File: rtl/spi_target_edgedet.sv
// SPI pin conditioning for the target: synchronizes SCK, CS and MOSI into the PCLK
// domain and turns SCK/CS transitions into single-cycle registered pulses.
// SCK is synchronized as SCK^CPOL so the idle level is always 0 and the reset value is constant.
module spi_target_edgedet #(
    parameter int SYNCW = 2
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic SPICLK,
    input  logic SPICS,
    input  logic SPIMOSI,
    input  logic CPOL,
    input  logic CPHA,
    output logic SamplePulse,
    output logic ShiftPulse,
    output logic CsFall,
    output logic CsRise,
    output logic MosiS
);

    logic [SYNCW-1:0] sck_sync_q;
    logic [SYNCW-1:0] cs_sync_q;
    logic [SYNCW-1:0] mosi_sync_q;
    logic             sck_prev_q;
    logic             cs_prev_q;
    logic             sck_lead;
    logic             sck_trail;

    // Leading edge is the move away from the idle level, i.e. a rise of the normalized SCK.
    assign sck_lead  =  sck_sync_q[SYNCW-1] & ~sck_prev_q;
    assign sck_trail = ~sck_sync_q[SYNCW-1] &  sck_prev_q;

    // Synchronizer chains, edge history and registered edge pulses (pulse lands SYNCW+1 cycles after the pin edge).
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            SamplePulse <= 1'b0;
            ShiftPulse  <= 1'b0;
            CsFall      <= 1'b0;
            CsRise      <= 1'b0;
            MosiS       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every stage shifts from its pre-edge value, forming a real chain.
            sck_sync_q  <= {sck_sync_q[SYNCW-2:0], SPICLK ^ CPOL};
            cs_sync_q   <= {cs_sync_q[SYNCW-2:0], SPICS};
            mosi_sync_q <= {mosi_sync_q[SYNCW-2:0], SPIMOSI};
            sck_prev_q  <= sck_sync_q[SYNCW-1];
            cs_prev_q   <= cs_sync_q[SYNCW-1];
            SamplePulse <= CPHA ? sck_trail : sck_lead;
            ShiftPulse  <= CPHA ? sck_lead  : sck_trail;
            CsFall      <= ~cs_sync_q[SYNCW-1] &  cs_prev_q;
            CsRise      <=  cs_sync_q[SYNCW-1] & ~cs_prev_q;
            MosiS       <= mosi_sync_q[SYNCW-1];
        end
    end

endmodule

// File: rtl/spi_target_regs.sv
// SPI target exposing NREGS 8-bit registers. Byte 0 of a frame is {RnW, ADDR},
// following bytes are data with auto-incrementing, wrapping address.
// Optional feature macro SPI_TARGET_STATUS_EN: status byte = {4'hA, count of SPI writes mod 16};
// without it the status byte is 8'h00.
module spi_target_regs
    import cvw::*;
#(
    parameter int NREGS = 16,
    parameter int SYNCW = 2
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     SPICLK,
    input  logic                     SPICS,
    input  logic                     SPIMOSI,
    output logic                     SPIMISO,
    input  logic                     CPOL,
    input  logic                     CPHA,
    input  logic                     HostWrEn,
    input  logic [$clog2(NREGS)-1:0] HostWrAddr,
    input  logic [7:0]               HostWrData,
    output logic [8*NREGS-1:0]       RegVec,
    output logic                     SpiWrPulse,
    output logic [$clog2(NREGS)-1:0] SpiWrAddr,
    output logic                     FrameErr
);

    localparam int AW = $clog2(NREGS);

    logic          sample_pulse, shift_pulse, cs_fall, cs_rise, mosi_s;
    spit_state_t   state_q;
    logic [2:0]    bitcnt_q;
    logic [6:0]    rx_q;
    logic [7:0]    tx_q;
    logic          fresh_q;
    logic          rnw_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    regs_q [NREGS];
    logic          wr_pulse_q;
    logic [AW-1:0] wr_addr_q;
    logic          frame_err_q;
    logic [7:0]    status;
    logic [7:0]    rx_full;
    logic [AW-1:0] cmd_addr;
    logic          byte_done;
    logic          spi_commit;

    spi_target_edgedet #(.SYNCW(SYNCW)) u_edgedet (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .SPICLK      (SPICLK),
        .SPICS       (SPICS),
        .SPIMOSI     (SPIMOSI),
        .CPOL        (CPOL),
        .CPHA        (CPHA),
        .SamplePulse (sample_pulse),
        .ShiftPulse  (shift_pulse),
        .CsFall      (cs_fall),
        .CsRise      (cs_rise),
        .MosiS       (mosi_s)
    );

    // Byte as it will look once the current sample is shifted in.
    assign rx_full    = {rx_q, mosi_s};
    assign cmd_addr   = rx_full[AW-1:0];
    assign byte_done  = (state_q != SPIT_IDLE) && sample_pulse && (bitcnt_q == 3'd7) && !cs_rise && !cs_fall;
    assign spi_commit = byte_done && (state_q == SPIT_DATA) && !rnw_q;

`ifdef SPI_TARGET_STATUS_EN
    logic [3:0] wr_count_q;

    // Counts committed SPI writes, wrapping at 16.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)        wr_count_q <= 4'd0;
        else if (spi_commit) wr_count_q <= wr_count_q + 4'd1;
    end

    assign status = {4'hA, wr_count_q};
`else
    assign status = 8'h00;
`endif

    // Frame FSM with Rx/Tx shifters, bit and address counters, commit pulse and frame error flag.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= SPIT_IDLE;
            bitcnt_q    <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'h00;
            fresh_q     <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_pulse_q <= spi_commit;
            if (spi_commit) wr_addr_q <= addr_q;

            if (cs_rise) begin
                // A rise with bits pending abandons the partial byte.
                if (state_q != SPIT_IDLE && bitcnt_q != 3'd0) frame_err_q <= 1'b1;
                state_q <= SPIT_IDLE;
            end else if (cs_fall) begin
                state_q     <= SPIT_CMD;
                bitcnt_q    <= 3'd0;
                tx_q        <= status;
                fresh_q     <= CPHA;
                frame_err_q <= 1'b0;
            end else if (state_q != SPIT_IDLE) begin
                // Fresh holds off the first shift so a newly loaded MSB stays on MISO for one bit.
                if (shift_pulse) begin
                    if (fresh_q) fresh_q <= 1'b0;
                    else         tx_q    <= {tx_q[6:0], 1'b0};
                end
                if (sample_pulse) begin
                    rx_q     <= rx_full[6:0];
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
                if (byte_done) begin
                    fresh_q <= 1'b1;
                    if (state_q == SPIT_CMD) begin
                        state_q <= SPIT_DATA;
                        rnw_q   <= rx_full[SPIT_RNW_BIT];
                        if (rx_full[SPIT_RNW_BIT]) begin
                            tx_q   <= regs_q[cmd_addr];
                            addr_q <= cmd_addr + 1'b1;
                        end else begin
                            tx_q   <= 8'h00;
                            addr_q <= cmd_addr;
                        end
                    end else begin
                        tx_q   <= rnw_q ? regs_q[addr_q] : 8'h00;
                        addr_q <= addr_q + 1'b1;
                    end
                end
            end
        end
    end

    // Register file: host writes, then SPI commit, so SPI wins on an address collision.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            // NOTE: this array is reset because its contents are architecturally visible at reset; plain RAMs normally are not.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
        end else begin
            if (HostWrEn)   regs_q[HostWrAddr] <= HostWrData;
            if (spi_commit) regs_q[addr_q]     <= rx_full;
        end
    end

    // Flatten the register file onto RegVec.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned and infers a latch.
        RegVec = '0;
        for (int i = 0; i < NREGS; i++) RegVec[8*i +: 8] = regs_q[i];
    end

    assign SPIMISO    = (state_q != SPIT_IDLE) & tx_q[7];
    assign SpiWrPulse = wr_pulse_q;
    assign SpiWrAddr  = wr_addr_q;
    assign FrameErr   = frame_err_q;

endmodule
